// File: rtl/ftoi_arbiter.sv
// Shares one fixed-latency pipelined float->int unit between NREQ requesters with a one-hot grant.
// Latency: exactly LAT cycles from handshake to rsp_valid; one issue per cycle; results return in issue order.
// Backpressure: requesters wait on req_ready; responses cannot be stalled. Macro FTOI_ARB_FIXPRIO_EN selects fixed priority.
module ftoi_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT  = 1,
  parameter int IW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_a,
  output logic [NREQ-1:0]   req_ready,
  output logic [31:0]       fu_a,
  input  logic [31:0]       fu_res,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              busy
);

  logic          grant_any;
  logic [IW-1:0] gnt_idx;

  // Tag pipe: one {v, idx} entry per cycle of unit latency.
  logic [LAT-1:0] v_q;
  logic [IW-1:0]  idx_q [LAT];

`ifndef FTOI_ARB_FIXPRIO_EN
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
`endif

  // Pick the first valid requester, starting at the round-robin pointer (or index 0 in fixed priority).
  always_comb begin
    int j;
    j         = 0;
    grant_any = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef FTOI_ARB_FIXPRIO_EN
      j = k;
`else
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
`endif
      if (!grant_any && req_valid[j]) begin
        grant_any = 1'b1;
        gnt_idx   = IW'(j);
      end
    end
    // Nothing may be accepted while the block is held in reset.
    if (rst) begin
      grant_any = 1'b0;
      gnt_idx   = '0;
    end
  end

  // Drive the one-hot grant and steer the granted operand onto the shared unit input.
  always_comb begin
    req_ready = '0;
    fu_a      = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_any && gnt_idx == IW'(k)) begin
        req_ready[k] = 1'b1;
        fu_a         = req_a[32*k +: 32];
      end
    end
  end

`ifndef FTOI_ARB_FIXPRIO_EN
  // The pointer moves just past the winner; it holds when nobody is granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      if (gnt_idx == IW'(NREQ - 1)) rr_ptr_d = '0;
      else                          rr_ptr_d = gnt_idx + IW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Tag pipe mirrors the unit's pipeline so each result knows its owner; reset drops in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < LAT; k++) idx_q[k] <= '0;
    end else begin
      v_q[0]   <= grant_any;
      idx_q[0] <= gnt_idx;
      for (int k = 1; k < LAT; k++) begin
        v_q[k]   <= v_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  // Route the unit's result to the owner of the oldest tag; data is passed through unchanged.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (v_q[LAT-1]) begin
      for (int k = 0; k < NREQ; k++) begin
        if (idx_q[LAT-1] == IW'(k)) rsp_valid[k] = 1'b1;
      end
      rsp_data = fu_res;
    end
  end

  assign busy = |v_q;

endmodule
